// File: rtl/e_nexthop_route_unit.sv
// East-port route computation: derives an XY next-hop from each head flit,
// writes it to the next-hop register and holds it until the packet's tail leaves.
module e_nexthop_route_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int X_W        = 2,
  parameter int Y_W        = 2,
  parameter int MY_X       = 0,
  parameter int MY_Y       = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ib_empty_i,
  input  logic [DATA_WIDTH-1:0] ib_data_i,
  input  logic                  ib_pop_i,
  output logic [2:0]            nhr_address_o,
  output logic                  nhr_write_o,
  output logic                  route_busy_o,
  output logic                  err_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    ROUTE = 1'b1
  } state_e;

  localparam logic [1:0] FT_BODY   = 2'b00;
  localparam logic [1:0] FT_HEAD   = 2'b01;
  localparam logic [1:0] FT_TAIL   = 2'b10;
  localparam logic [1:0] FT_SINGLE = 2'b11;

  localparam logic [2:0] NH_NORTH = 3'b000;
  localparam logic [2:0] NH_SOUTH = 3'b010;
  localparam logic [2:0] NH_NONE  = 3'b011;
  localparam logic [2:0] NH_WEST  = 3'b100;
  localparam logic [2:0] NH_LOCAL = 3'b101;

  localparam logic [X_W-1:0] MY_X_C = X_W'(MY_X);
  localparam logic [Y_W-1:0] MY_Y_C = Y_W'(MY_Y);

  state_e         state_q, state_d;
  logic [2:0]     route_q, route_d;
  logic [2:0]     nhrAddr_q, nhrAddr_d;
  logic           nhrWrite_q, nhrWrite_d;
  logic           err_q, err_d;
  logic           emptyPrev_q;

  logic [1:0]     flitType;
  logic [X_W-1:0] destX;
  logic [Y_W-1:0] destY;
  logic           isLast;
  logic [2:0]     calcRoute;
  logic           calcErr;
  logic           unusedPayload;

  assign flitType      = ib_data_i[DATA_WIDTH-1 -: 2];
  assign destX         = ib_data_i[X_W-1:0];
  assign destY         = ib_data_i[X_W+Y_W-1:X_W];
  assign isLast        = (flitType == FT_TAIL) || (flitType == FT_SINGLE);
  assign unusedPayload = ^ib_data_i[DATA_WIDTH-3:X_W+Y_W];

  // XY decision; an East result would send the packet back out the port it
  // came in on, so it is flagged and delivered locally instead.
  always_comb begin
    calcRoute = NH_LOCAL;
    calcErr   = 1'b0;
    if (flitType == FT_BODY || flitType == FT_TAIL) begin
      calcErr = 1'b1;
    end else if (destX > MY_X_C) begin
      calcErr = 1'b1;
    end else if (destX < MY_X_C) begin
      calcRoute = NH_WEST;
    end else if (destY > MY_Y_C) begin
      calcRoute = NH_NORTH;
    end else if (destY < MY_Y_C) begin
      calcRoute = NH_SOUTH;
    end
  end

  always_comb begin
    state_d    = state_q;
    route_d    = route_q;
    nhrAddr_d  = nhrAddr_q;
    nhrWrite_d = 1'b0;
    err_d      = err_q;
    if (ib_pop_i && ib_empty_i) begin
      err_d = 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (ib_pop_i) begin
          err_d = 1'b1;
        end else if (!ib_empty_i) begin
          route_d    = calcRoute;
          nhrAddr_d  = calcRoute;
          nhrWrite_d = 1'b1;
          state_d    = ROUTE;
          if (calcErr) begin
            err_d = 1'b1;
          end
        end
      end
      ROUTE: begin
        // The next-hop register clears itself while the buffer is empty, so a
        // refill must restore the held route; a tail pop takes precedence.
        if (ib_pop_i && !ib_empty_i && isLast) begin
          route_d    = NH_NONE;
          nhrAddr_d  = NH_NONE;
          nhrWrite_d = 1'b1;
          state_d    = IDLE;
        end else if (emptyPrev_q && !ib_empty_i) begin
          nhrAddr_d  = route_q;
          nhrWrite_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      route_q     <= NH_NONE;
      nhrAddr_q   <= NH_NONE;
      nhrWrite_q  <= 1'b0;
      err_q       <= 1'b0;
      emptyPrev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      route_q     <= route_d;
      nhrAddr_q   <= nhrAddr_d;
      nhrWrite_q  <= nhrWrite_d;
      err_q       <= err_d;
      emptyPrev_q <= ib_empty_i;
    end
  end

  assign nhr_address_o = nhrAddr_q;
  assign nhr_write_o   = nhrWrite_q;
  assign route_busy_o  = (state_q == ROUTE);
  assign err_o         = err_q;

endmodule

// File: tb/tb_e_nexthop_route_unit.sv
// Bench for e_nexthop_route_unit: two routers, (0,0) and (1,1), share one input
// stream and are compared every cycle against a packet-level model.
module tb_e_nexthop_route_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ibEmpty;
  logic        ibPop;
  logic [31:0] ibData;
  wire  [2:0]  addr0, addr1;
  wire         wr0, wr1, busy0, busy1, err0, err1;

  int totalCount = 0;
  int badCount   = 0;
  logic checkEn  = 1'b0;

  // Literal expectations are handed to the compare process through these.
  int         litSeq  = 0;
  int         litDone = 0;
  string      litName;
  int         litInst;
  logic       litWr, litBusy, litErr;
  logic [2:0] litAddr;

  logic        mBusy, mWr, mPrevEmpty;
  logic [2:0]  mAddr [2];
  logic [2:0]  mRoute [2];
  logic        mErr [2];
  logic [31:0] flitQ [$];

  always #5 clk = ~clk;

  e_nexthop_route_unit #(.DATA_WIDTH(32), .X_W(2), .Y_W(2), .MY_X(0), .MY_Y(0)) u0 (
    .clk(clk), .reset(reset), .ib_empty_i(ibEmpty), .ib_data_i(ibData), .ib_pop_i(ibPop),
    .nhr_address_o(addr0), .nhr_write_o(wr0), .route_busy_o(busy0), .err_o(err0));

  e_nexthop_route_unit #(.DATA_WIDTH(32), .X_W(2), .Y_W(2), .MY_X(1), .MY_Y(1)) u1 (
    .clk(clk), .reset(reset), .ib_empty_i(ibEmpty), .ib_data_i(ibData), .ib_pop_i(ibPop),
    .nhr_address_o(addr1), .nhr_write_o(wr1), .route_busy_o(busy1), .err_o(err1));

  // {error, next-hop} a head flit deserves at router (mx,my).
  function automatic logic [3:0] routeOf(input logic [31:0] f, input int mx, input int my);
    int dx, dy;
    logic [1:0] t;
    t  = f[31:30];
    dx = int'(f[1:0]);
    dy = int'(f[3:2]);
    if (t == 2'b00 || t == 2'b10) return 4'b1101;
    if (dx > mx) return 4'b1101;
    if (dx < mx) return 4'b0100;
    if (dy > my) return 4'b0000;
    if (dy < my) return 4'b0010;
    return 4'b0101;
  endfunction

  function automatic logic [31:0] fl(input logic [1:0] t, input int dx, input int dy);
    logic [1:0] x, y;
    x = dx[1:0];
    y = dy[1:0];
    return {t, 26'h0, y, x};
  endfunction

  function automatic logic [31:0] mkFlit(input logic [1:0] t);
    logic [31:0] f;
    f = $urandom;
    f[31:30] = t;
    return f;
  endfunction

  // Packet-level model: router instance i sits at coordinates (i,i).
  always @(posedge clk or posedge reset) begin
    logic [3:0] r;
    if (reset) begin
      mBusy      <= 1'b0;
      mWr        <= 1'b0;
      mPrevEmpty <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        mAddr[i]  <= 3'b011;
        mRoute[i] <= 3'b011;
        mErr[i]   <= 1'b0;
      end
    end else begin
      mWr        <= 1'b0;
      mPrevEmpty <= ibEmpty;
      if (ibPop && (ibEmpty || !mBusy)) begin
        for (int i = 0; i < 2; i++) mErr[i] <= 1'b1;
      end
      if (!mBusy) begin
        if (!ibPop && !ibEmpty) begin
          mBusy <= 1'b1;
          mWr   <= 1'b1;
          for (int i = 0; i < 2; i++) begin
            r = routeOf(ibData, i, i);
            mAddr[i]  <= r[2:0];
            mRoute[i] <= r[2:0];
            if (r[3]) mErr[i] <= 1'b1;
          end
        end
      end else if (ibPop && !ibEmpty && (ibData[31:30] == 2'b10 || ibData[31:30] == 2'b11)) begin
        mBusy <= 1'b0;
        mWr   <= 1'b1;
        for (int i = 0; i < 2; i++) mAddr[i] <= 3'b011;
      end else if (mPrevEmpty && !ibEmpty) begin
        mWr <= 1'b1;
        for (int i = 0; i < 2; i++) mAddr[i] <= mRoute[i];
      end
    end
  end

  task automatic compareVal(input string nm, input logic [2:0] act, input logic [2:0] exp);
    totalCount++;
    if (act !== exp) begin
      badCount++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h time=%0t", nm, act, exp, $time);
    end
  endtask

  // Compare process, sampling on the falling edge.
  always begin
    @(negedge clk);
    if (checkEn) begin
      compareVal("addr0", addr0, mAddr[0]);
      compareVal("addr1", addr1, mAddr[1]);
      compareVal("wr0", {2'b0, wr0}, {2'b0, mWr});
      compareVal("wr1", {2'b0, wr1}, {2'b0, mWr});
      compareVal("busy0", {2'b0, busy0}, {2'b0, mBusy});
      compareVal("busy1", {2'b0, busy1}, {2'b0, mBusy});
      compareVal("err0", {2'b0, err0}, {2'b0, mErr[0]});
      compareVal("err1", {2'b0, err1}, {2'b0, mErr[1]});
    end
    if (litSeq != litDone) begin
      litDone = litSeq;
      compareVal({litName, " addr"}, (litInst == 0) ? addr0 : addr1, litAddr);
      compareVal({litName, " wr"}, {2'b0, (litInst == 0) ? wr0 : wr1}, {2'b0, litWr});
      compareVal({litName, " busy"}, {2'b0, (litInst == 0) ? busy0 : busy1}, {2'b0, litBusy});
      compareVal({litName, " err"}, {2'b0, (litInst == 0) ? err0 : err1}, {2'b0, litErr});
    end
  end

  task automatic applyStimulus(input logic e, input logic [31:0] d, input logic p);
    @(posedge clk);
    #1;
    ibEmpty = e;
    ibData  = d;
    ibPop   = p;
  endtask

  task automatic checkOutput(input string nm, input int inst, input logic wr,
                             input logic [2:0] addr, input logic busy, input logic err);
    litName = nm;
    litInst = inst;
    litWr   = wr;
    litAddr = addr;
    litBusy = busy;
    litErr  = err;
    litSeq++;
  endtask

  task automatic doReset();
    @(posedge clk);
    #3;
    reset   = 1'b1;
    ibEmpty = 1'b1;
    ibPop   = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
  endtask

  task automatic pushPacket();
    int k;
    int n;
    k = $urandom_range(0, 9);
    if (k == 0) begin
      n = $urandom_range(0, 2);
      repeat (n) flitQ.push_back(mkFlit(2'b00));
      flitQ.push_back(mkFlit(2'b10));
    end else if (k < 4) begin
      flitQ.push_back(mkFlit(2'b11));
    end else begin
      flitQ.push_back(mkFlit(2'b01));
      n = $urandom_range(0, 3);
      repeat (n) flitQ.push_back(mkFlit(2'b00));
      flitQ.push_back(mkFlit(2'b10));
    end
  endtask

  logic [31:0] sweepFlit;
  logic [2:0]  sweepAddr [4] = '{3'b100, 3'b010, 3'b101, 3'b101};
  int          sweepDx   [4] = '{0, 1, 1, 2};
  int          sweepDy   [4] = '{3, 0, 1, 1};
  logic        sweepErr  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    reset   = 1'b0;
    ibEmpty = 1'b1;
    ibPop   = 1'b0;
    ibData  = 32'h0;
    #2;
    doReset();
    checkEn = 1'b1;

    // Router (0,0), 3-flit packet to (0,2).
    applyStimulus(1'b1, 32'h0, 1'b0);
    checkOutput("reset state", 0, 1'b0, 3'b011, 1'b0, 1'b0);
    applyStimulus(1'b0, fl(2'b01, 0, 2), 1'b0);
    applyStimulus(1'b0, fl(2'b01, 0, 2), 1'b1);
    checkOutput("t1 head", 0, 1'b1, 3'b000, 1'b1, 1'b0);
    applyStimulus(1'b0, fl(2'b00, 0, 0), 1'b1);
    checkOutput("t1 body", 0, 1'b0, 3'b000, 1'b1, 1'b0);
    applyStimulus(1'b0, fl(2'b10, 0, 0), 1'b1);
    checkOutput("t1 tailpop", 0, 1'b0, 3'b000, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0, 1'b0);
    checkOutput("t1 none", 0, 1'b1, 3'b011, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0, 1'b0);
    checkOutput("t1 idle", 0, 1'b0, 3'b011, 1'b0, 1'b0);

    // Router (1,1) routing sweep with single-flit packets.
    for (int s = 0; s < 4; s++) begin
      sweepFlit = fl(2'b11, sweepDx[s], sweepDy[s]);
      applyStimulus(1'b0, sweepFlit, 1'b0);
      applyStimulus(1'b0, sweepFlit, 1'b1);
      checkOutput("sweep route", 1, 1'b1, sweepAddr[s], 1'b1, sweepErr[s]);
      applyStimulus(1'b1, 32'h0, 1'b0);
      checkOutput("sweep none", 1, 1'b1, 3'b011, 1'b0, sweepErr[s]);
    end

    // Single flit, back-to-back head, then an empty gap and refill.
    doReset();
    applyStimulus(1'b0, fl(2'b11, 0, 1), 1'b0);
    applyStimulus(1'b0, fl(2'b11, 0, 1), 1'b1);
    checkOutput("single route", 1, 1'b1, 3'b100, 1'b1, 1'b0);
    applyStimulus(1'b0, fl(2'b01, 1, 3), 1'b0);
    checkOutput("single none", 1, 1'b1, 3'b011, 1'b0, 1'b0);
    applyStimulus(1'b0, fl(2'b01, 1, 3), 1'b0);
    checkOutput("b2b route", 1, 1'b1, 3'b000, 1'b1, 1'b0);
    applyStimulus(1'b0, fl(2'b01, 1, 3), 1'b1);
    checkOutput("b2b hold", 1, 1'b0, 3'b000, 1'b1, 1'b0);
    for (int g = 0; g < 3; g++) begin
      applyStimulus(1'b1, 32'h0, 1'b0);
      checkOutput("gap nowrite", 1, 1'b0, 3'b000, 1'b1, 1'b0);
    end
    applyStimulus(1'b0, fl(2'b10, 0, 0), 1'b0);
    checkOutput("fall nowrite", 1, 1'b0, 3'b000, 1'b1, 1'b0);
    applyStimulus(1'b0, fl(2'b10, 0, 0), 1'b0);
    checkOutput("refill write", 1, 1'b1, 3'b000, 1'b1, 1'b0);
    applyStimulus(1'b0, fl(2'b10, 0, 0), 1'b1);
    checkOutput("refill once", 1, 1'b0, 3'b000, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0, 1'b0);
    checkOutput("b2b none", 1, 1'b1, 3'b011, 1'b0, 1'b0);

    // Stray body flit in IDLE.
    applyStimulus(1'b0, fl(2'b00, 0, 0), 1'b0);
    applyStimulus(1'b0, fl(2'b00, 0, 0), 1'b1);
    checkOutput("stray route", 1, 1'b1, 3'b101, 1'b1, 1'b1);
    applyStimulus(1'b0, fl(2'b10, 0, 0), 1'b1);
    checkOutput("stray hold", 1, 1'b0, 3'b101, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'h0, 1'b0);
    checkOutput("stray none", 1, 1'b1, 3'b011, 1'b0, 1'b1);

    // Asynchronous reset while a route write is on the outputs.
    applyStimulus(1'b0, fl(2'b01, 0, 2), 1'b0);
    applyStimulus(1'b0, fl(2'b01, 0, 2), 1'b0);
    #2;
    reset   = 1'b1;
    ibEmpty = 1'b1;
    checkOutput("async reset", 1, 1'b0, 3'b011, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    applyStimulus(1'b0, fl(2'b01, 0, 2), 1'b0);
    applyStimulus(1'b0, fl(2'b01, 0, 2), 1'b1);
    checkOutput("post reset route", 1, 1'b1, 3'b100, 1'b1, 1'b0);
    applyStimulus(1'b0, fl(2'b10, 0, 0), 1'b1);
    checkOutput("post reset hold", 1, 1'b0, 3'b100, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0, 1'b0);
    checkOutput("post reset none", 1, 1'b1, 3'b011, 0, 1'b0);

    // Random packet streams with gaps; resets strand partial packets as strays.
    for (int seg = 0; seg < 4; seg++) begin
      doReset();
      for (int c = 0; c < 500; c++) begin
        @(posedge clk);
        #1;
        if (ibPop) void'(flitQ.pop_front());
        while (flitQ.size() < 6) pushPacket();
        ibEmpty = ($urandom_range(0, 4) == 0);
        ibData  = ibEmpty ? $urandom : flitQ[0];
        ibPop   = mBusy && !ibEmpty && ($urandom_range(0, 2) != 0);
      end
      @(posedge clk);
      #1;
      if (ibPop) void'(flitQ.pop_front());
      ibPop   = 1'b0;
      ibEmpty = 1'b1;
    end

    repeat (2) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
